// File: rtl/adc_sample_bank.sv
// ADC response demultiplexer: captures mapped channels into per-slot raw registers and
// publishes a coherent snapshot per frame. Optional frame averaging with ADC_BANK_AVG_EN.
module adc_sample_bank #(
  parameter int                  NUM_CH   = 5,
  parameter int                  DATA_W   = 12,
  parameter logic [5*NUM_CH-1:0] CH_MAP   = {5'd4, 5'd2, 5'd1, 5'd6, 5'd3},
  parameter int                  AVG_LOG2 = 2
) (
  input  logic                  clk_core,
  input  logic                  reset,
  input  logic                  rsp_valid,
  input  logic [4:0]            rsp_channel,
  input  logic [DATA_W-1:0]     rsp_data,
  input  logic                  rsp_eop,
  input  logic                  hold,
  input  logic                  reg_rd,
  input  logic [7:0]            reg_addr,
  output logic [7:0]            reg_rdata,
  output logic [16*NUM_CH-1:0]  sample_flat,
  output logic                  frame_ready
);

  if (NUM_CH < 1 || NUM_CH > 16 || DATA_W < 8 || DATA_W > 16 ||
      AVG_LOG2 < 0 || AVG_LOG2 > 4) begin : g_param_check
    $error("adc_sample_bank: parameter out of legal range");
  end

  logic [DATA_W-1:0] raw       [NUM_CH];
  logic [15:0]       published [NUM_CH];
  logic [15:0]       pub_value [NUM_CH];
  logic              pending;
  logic              status_new;
  logic              overrun;
  logic [7:0]        seq_count;
  logic [7:0]        rd_byte;
  logic              eop_in;
  logic              consume;
  logic              publish;
  logic              rd_status;

  assign eop_in    = rsp_valid && rsp_eop;
  assign consume   = pending && !hold;
  assign rd_status = reg_rd && (reg_addr == 8'h00);

`ifdef ADC_BANK_AVG_EN
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc [NUM_CH];
  logic [ACC_W-1:0] sum [NUM_CH];
  logic [CNT_W-1:0] frame_cnt;

  // Only the last frame of a window publishes; the others just fold into acc.
  assign publish = consume && (frame_cnt == LAST_FRAME);

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i]       = acc[i] + ACC_W'(raw[i]);
      pub_value[i] = 16'(sum[i] >> AVG_LOG2);
    end
  end

  always_ff @(posedge clk_core) begin
    if (reset) begin
      frame_cnt <= '0;
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
    end else if (consume) begin
      if (publish) begin
        frame_cnt <= '0;
        for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
      end else begin
        frame_cnt <= frame_cnt + CNT_W'(1);
        for (int i = 0; i < NUM_CH; i++) acc[i] <= sum[i];
      end
    end
  end
`else
  assign publish = consume;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) pub_value[i] = 16'(raw[i]);
  end
`endif

  always_ff @(posedge clk_core) begin
    if (reset) begin
      // NOTE: the raw and published arrays are reset explicitly so a reset
      // mid-frame can never leak stale samples into the next snapshot.
      for (int i = 0; i < NUM_CH; i++) begin
        raw[i]       <= '0;
        published[i] <= '0;
      end
      pending     <= 1'b0;
      status_new  <= 1'b0;
      overrun     <= 1'b0;
      seq_count   <= 8'h00;
      frame_ready <= 1'b0;
      reg_rdata   <= 8'h00;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (rsp_valid && (rsp_channel == CH_MAP[5*i +: 5])) raw[i] <= rsp_data;
      end

      // A new eop keeps pending set even if the old frame is consumed this cycle.
      if (eop_in)       pending <= 1'b1;
      else if (consume) pending <= 1'b0;

      frame_ready <= publish;
      if (publish) begin
        for (int i = 0; i < NUM_CH; i++) published[i] <= pub_value[i];
        seq_count <= seq_count + 8'd1;
      end

      if (publish)        status_new <= 1'b1;
      else if (rd_status) status_new <= 1'b0;

      if (eop_in && pending) overrun <= 1'b1;
      else if (rd_status)    overrun <= 1'b0;

      if (reg_rd) reg_rdata <= rd_byte;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the decode can leave it unassigned and infer a latch.
    rd_byte = 8'h00;
    case (reg_addr)
      8'h00:   rd_byte = {6'b0, overrun, status_new};
      8'h01:   rd_byte = seq_count;
      8'h02:   rd_byte = 8'(NUM_CH);
      default: rd_byte = 8'h00;
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      if (reg_addr == 8'(3 + 2*i)) rd_byte = published[i][7:0];
      if (reg_addr == 8'(4 + 2*i)) rd_byte = published[i][15:8];
    end
  end

  always_comb begin
    sample_flat = '0;
    for (int i = 0; i < NUM_CH; i++) sample_flat[16*i +: 16] = published[i];
  end

endmodule

// File: tb/tb_adc_sample_bank.sv
// Directed bench for adc_sample_bank: a slot model pushes expected snapshots to a queue
// on each frame and they are popped when frame_ready pulses.
module tb_adc_sample_bank;
  localparam int NUM_CH = 5;
  localparam int DATA_W = 12;
  localparam int MAP [NUM_CH] = '{3, 6, 1, 2, 4};

  logic                 clk_core = 1'b0;
  logic                 reset = 1'b1;
  logic                 rsp_valid = 1'b0;
  logic [4:0]           rsp_channel = '0;
  logic [DATA_W-1:0]    rsp_data = '0;
  logic                 rsp_eop = 1'b0;
  logic                 hold = 1'b0;
  logic                 reg_rd = 1'b0;
  logic [7:0]           reg_addr = '0;
  logic [7:0]           reg_rdata;
  logic [16*NUM_CH-1:0] sample_flat;
  logic                 frame_ready;

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  logic [15:0]          m_raw [NUM_CH];
  logic [7:0]           m_seq;
  logic [16*NUM_CH-1:0] exp_q [$];

  adc_sample_bank #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk_core    (clk_core),
    .reset       (reset),
    .rsp_valid   (rsp_valid),
    .rsp_channel (rsp_channel),
    .rsp_data    (rsp_data),
    .rsp_eop     (rsp_eop),
    .hold        (hold),
    .reg_rd      (reg_rd),
    .reg_addr    (reg_addr),
    .reg_rdata   (reg_rdata),
    .sample_flat (sample_flat),
    .frame_ready (frame_ready)
  );

  always #5 clk_core = ~clk_core;

  always @(negedge clk_core) if (frame_ready) pulses++;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16*NUM_CH-1:0] model_flat();
    logic [16*NUM_CH-1:0] f;
    f = '0;
    for (int i = 0; i < NUM_CH; i++) f[16*i +: 16] = m_raw[i];
    return f;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_CH; i++) m_raw[i] = 16'h0000;
    m_seq = 8'h00;
    exp_q.delete();
  endtask

  task automatic push_expected();
    exp_q.push_back(model_flat());
    m_seq = m_seq + 8'd1;
  endtask

  task automatic send(input logic [4:0] ch, input logic [DATA_W-1:0] d, input logic eop);
    @(negedge clk_core);
    rsp_valid = 1'b1;
    rsp_channel = ch;
    rsp_data = d;
    rsp_eop = eop;
    for (int i = 0; i < NUM_CH; i++) if (MAP[i] == int'(ch)) m_raw[i] = 16'(d);
    @(negedge clk_core);
    rsp_valid = 1'b0;
    rsp_eop = 1'b0;
  endtask

  task automatic wait_publish(input int bound);
    logic [16*NUM_CH-1:0] exp;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_core);
      if (frame_ready) begin
        seen = 1'b1;
        break;
      end
    end
    check("publish_seen", 128'(seen), 128'(1));
    if (seen) begin
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check("sample_flat", 128'(sample_flat), 128'(exp));
      @(negedge clk_core);
      check("frame_ready_one_cycle", 128'(frame_ready), 128'(0));
    end
  endtask

  task automatic reg_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk_core);
    reg_rd = 1'b1;
    reg_addr = a;
    @(negedge clk_core);
    reg_rd = 1'b0;
    d = reg_rdata;
  endtask

  task automatic check_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    reg_read(a, d);
    check(tag, 128'(d), 128'(exp));
  endtask

  task automatic do_reset();
    @(negedge clk_core);
    reset = 1'b1;
    repeat (2) @(negedge clk_core);
    reset = 1'b0;
    model_clear();
  endtask

  // eop is captured, then reset lands before the frame can be consumed.
  task automatic reset_midframe_test();
    int p;
    p = pulses;
    send(5'd2, 12'h042, 1'b1);
    reset = 1'b1;
    repeat (2) @(negedge clk_core);
    reset = 1'b0;
    model_clear();
    repeat (3) @(negedge clk_core);
    check("reset_no_publish", 128'(pulses), 128'(p));
    check("reset_flat_zero", 128'(sample_flat), 128'(0));
    for (int a = 0; a < 16; a++) begin
      check_read($sformatf("reset_read_%0h", a), 8'(a), (a == 2) ? 8'h05 : 8'h00);
    end
  endtask

  initial begin
    int p;
    int n;
    logic [16*NUM_CH-1:0] prev;
    logic [16*NUM_CH-1:0] avg_exp;
    logic [7:0] d;
    logic [DATA_W-1:0] avg_vals [4];

    model_clear();
    do_reset();
    check("rst_frame_ready", 128'(frame_ready), 128'(0));
    check("rst_sample_flat", 128'(sample_flat), 128'(0));
    check_read("rst_status", 8'h00, 8'h00);
    check_read("rst_seq", 8'h01, 8'h00);
    check_read("rst_num_ch", 8'h02, 8'h05);

`ifndef ADC_BANK_AVG_EN
    // Basic frame with exact two-cycle publish latency.
    send(5'd3, 12'h123, 1'b0);
    send(5'd6, 12'h456, 1'b0);
    send(5'd1, 12'h789, 1'b0);
    send(5'd2, 12'hABC, 1'b0);
    send(5'd4, 12'hFFF, 1'b1);
    check("latency_early", 128'(frame_ready), 128'(0));
    push_expected();
    wait_publish(1);
    check("basic_flat_const", 128'(sample_flat), 128'(80'h0FFF_0ABC_0789_0456_0123));
    check_read("basic_seq", 8'h01, m_seq);
    check_read("basic_status", 8'h00, 8'h01);
    @(negedge clk_core);
    check("rdata_held", 128'(reg_rdata), 128'(8'h01));
    check_read("basic_status_cleared", 8'h00, 8'h00);

    // Unmapped channel must not touch any slot or publish.
    p = pulses;
    send(5'd7, 12'h555, 1'b0);
    repeat (3) @(negedge clk_core);
    check("unmapped_flat", 128'(sample_flat), 128'(model_flat()));
    check("unmapped_no_pulse", 128'(pulses), 128'(p));
    check_read("unmapped_addr", 8'h0F, 8'h00);

    // Hold across two frames: publish deferred, overrun flagged.
    prev = model_flat();
    p = pulses;
    @(negedge clk_core);
    hold = 1'b1;
    send(5'd3, 12'h111, 1'b1);
    send(5'd6, 12'h222, 1'b0);
    send(5'd4, 12'h333, 1'b1);
    repeat (4) @(negedge clk_core);
    check("hold_no_pulse", 128'(pulses), 128'(p));
    check("hold_flat_frozen", 128'(sample_flat), 128'(prev));
    push_expected();
    @(negedge clk_core);
    hold = 1'b0;
    wait_publish(1);
    check_read("hold_status", 8'h00, 8'h03);
    check_read("hold_status_cleared", 8'h00, 8'h00);

    // Run frames until seq_count wraps; last frame leaves slot0 = 0xABC.
    n = 256 - int'(m_seq);
    for (int i = 0; i < n; i++) begin
      send(5'd3, (i == n - 1) ? 12'hABC : 12'(i), 1'b1);
      push_expected();
      wait_publish(1);
    end
    check_read("wrap_seq", 8'h01, 8'h00);
    check_read("slot0_hi", 8'h04, 8'h0A);
    check_read("slot0_lo", 8'h03, 8'hBC);
    check_read("wrap_status", 8'h00, 8'h01);

    reset_midframe_test();

    // First eop after reset starts cleanly.
    send(5'd1, 12'h0AA, 1'b1);
    push_expected();
    wait_publish(1);
    check_read("post_reset_seq", 8'h01, m_seq);
`else
    avg_vals = '{12'd10, 12'd11, 12'd12, 12'd14};
    for (int i = 0; i < 4; i++) begin
      send(5'd3, avg_vals[i], 1'b1);
      if (i < 3) repeat (3) @(negedge clk_core);
    end
    check("avg_no_early_pulse", 128'(pulses), 128'(0));
    avg_exp = '0;
    avg_exp[15:0] = 16'h000B;
    exp_q.push_back(avg_exp);
    wait_publish(1);
    check_read("avg_seq", 8'h01, 8'h01);
    check_read("avg_status", 8'h00, 8'h01);
    check("avg_single_pulse", 128'(pulses), 128'(1));
    reset_midframe_test();
`endif

    reg_read(8'h02, d);
    check("final_num_ch", 128'(d), 128'(8'h05));
    check("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
